panel_sequencer: RTL and testbench

PANEL_SEQUENCER -- requirements
Module: panel_sequencer

---
 rtl/panel_pkg.sv | 38 +++
 rtl/bus_timer.sv | 41 ++++
 rtl/panel_sequencer.sv | 179 +++++++++++++++++
 tb/tb_panel_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/panel_pkg.sv
// Shared types and defaults for the front-panel sequencer.
// Holds the FSM state enum, command decode, width/timeout defaults and the
// display pattern shown after a bus timeout.
package panel_pkg;

    localparam int unsigned ADDR_W_DEF  = 16;
    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned TIMEOUT_DEF = 255;
    localparam int unsigned ENTRY_W     = 24;
    localparam int unsigned DISP_W      = 24;

    localparam logic [DISP_W-1:0] ERR_PATTERN = 24'hEEEEEE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        CMD_NONE = 3'd0,
        CMD_ADDR = 3'd1,
        CMD_DEP  = 3'd2,
        CMD_EXAM = 3'd3,
        CMD_NEXT = 3'd4
    } cmd_e;

    // Fixed priority: load-address > deposit > examine > next.
    function automatic cmd_e pick_cmd(input logic a, input logic d,
                                      input logic e, input logic n);
        if (a)      return CMD_ADDR;
        else if (d) return CMD_DEP;
        else if (e) return CMD_EXAM;
        else if (n) return CMD_NEXT;
        return CMD_NONE;
    endfunction

endpackage

// File: rtl/bus_timer.sv
// Bus-cycle watchdog counter.
// Ports: clk/rst (sync, active-high), clear_i zeroes the count, enable_i
// counts one per cycle, expired_c flags the cycle whose edge brings the
// count up to LIMIT.
module bus_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_c
);

    localparam int unsigned CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over enable.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Asserted while the upcoming edge would make the count equal LIMIT.
    assign expired_c = enable_i && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/panel_sequencer.sv
// Front-panel sequencer: turns keypad command pulses into single bus
// transactions against a halted target and drives the panel display.
// Ports: clk/rst (sync, active-high); stopped gates command acceptance;
// entry is the keypad value; cmd_addr/cmd_exam/cmd_dep/cmd_next are
// one-cycle command pulses; mem_* is a req/ack bus master; disp_value/
// disp_load feed the display; clear_entry clears the keypad; busy marks a
// transaction in flight; err is the sticky bus-timeout flag.
module panel_sequencer
    import panel_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stopped,
    input  logic [ENTRY_W-1:0]  entry,
    input  logic                cmd_addr,
    input  logic                cmd_exam,
    input  logic                cmd_dep,
    input  logic                cmd_next,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [DISP_W-1:0]   disp_value,
    output logic                disp_load,
    output logic                clear_entry,
    output logic                busy,
    output logic                err
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DISP_W-1:0]   disp_value_q, disp_value_d;
    logic                disp_load_q, disp_load_d;
    logic                clear_entry_q, clear_entry_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    cmd_e                cmd_c;
    logic                timer_clear_c;
    logic                timer_en_c;
    logic                expired_c;

    // High keypad bits beyond the address field never reach the datapath.
    logic                unused_entry_bits;
    assign unused_entry_bits = ^entry[ENTRY_W-1:ADDR_W];

    assign cmd_c      = pick_cmd(cmd_addr, cmd_dep, cmd_exam, cmd_next);
    assign timer_en_c = (state_q == REQ);

    bus_timer #(
        .LIMIT (TIMEOUT)
    ) u_bus_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (timer_clear_c),
        .enable_i  (timer_en_c),
        .expired_c (expired_c)
    );

    // Next-state and output decode.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        disp_value_d  = disp_value_q;
        disp_load_d   = 1'b0;
        clear_entry_d = 1'b0;
        busy_d        = busy_q;
        err_d         = err_q;
        timer_clear_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (stopped && (cmd_c != CMD_NONE)) begin
                    clear_entry_d = 1'b1;
                    err_d         = 1'b0;
                    if (cmd_c == CMD_ADDR) begin
                        addr_d       = entry[ADDR_W-1:0];
                        disp_value_d = DISP_W'({entry[ADDR_W-1:0], DATA_W'(0)});
                        disp_load_d  = 1'b1;
                    end else begin
                        state_d       = REQ;
                        mem_req_d     = 1'b1;
                        busy_d        = 1'b1;
                        timer_clear_c = 1'b1;
                        mem_we_d      = (cmd_c == CMD_DEP);
                        mem_addr_d    = addr_q;
                        if (cmd_c == CMD_DEP) begin
                            mem_wdata_d = entry[DATA_W-1:0];
                        end
                        if (cmd_c == CMD_NEXT) begin
                            addr_d     = addr_q + ADDR_W'(1);
                            mem_addr_d = addr_q + ADDR_W'(1);
                        end
                    end
                end
            end
            REQ: begin
                // An ack on the expiry cycle still counts as success.
                if (mem_ack) begin
                    state_d      = DONE;
                    mem_req_d    = 1'b0;
                    disp_load_d  = 1'b1;
                    disp_value_d = DISP_W'({addr_q, mem_we_q ? mem_wdata_q : mem_rdata});
                end else if (expired_c) begin
                    state_d      = IDLE;
                    mem_req_d    = 1'b0;
                    busy_d       = 1'b0;
                    err_d        = 1'b1;
                    disp_value_d = ERR_PATTERN;
                    disp_load_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (mem_we_q) begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            disp_value_q  <= '0;
            disp_load_q   <= 1'b0;
            clear_entry_q <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            disp_value_q  <= disp_value_d;
            disp_load_q   <= disp_load_d;
            clear_entry_q <= clear_entry_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign disp_value  = disp_value_q;
    assign disp_load   = disp_load_q;
    assign clear_entry = clear_entry_q;
    assign busy        = busy_q;
    assign err         = err_q;

endmodule

// File: tb/tb_panel_sequencer.sv
// Bench for panel_sequencer: directed table, reset corner cases and a
// randomized run checked against a transaction-level model.
module tb_panel_sequencer;

    localparam int TIMEOUT = 255;
    localparam int K_IGN = 0;
    localparam int K_ADR = 1;
    localparam int K_RD  = 2;
    localparam int K_WR  = 3;
    localparam int K_TO  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stopped = 1'b0;
    logic [23:0] entry = '0;
    logic        cmd_addr = 1'b0, cmd_exam = 1'b0, cmd_dep = 1'b0, cmd_next = 1'b0;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = '0;
    logic [23:0] disp_value;
    logic        disp_load, clear_entry, busy, err;

    int total = 0;
    int bad   = 0;
    logic err_exp = 1'b0;

    panel_sequencer dut (
        .clk(clk), .rst(rst), .stopped(stopped), .entry(entry),
        .cmd_addr(cmd_addr), .cmd_exam(cmd_exam), .cmd_dep(cmd_dep), .cmd_next(cmd_next),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .disp_value(disp_value), .disp_load(disp_load), .clear_entry(clear_entry),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cmd;   // {addr, dep, exam, next}
        logic        stp;
        logic [23:0] ent;
        int          dly;   // REQ cycles before ack; -1 = never
        logic [7:0]  rd;
        int          kind;
        logic [15:0] maddr;
        logic [7:0]  wd;
        logic [23:0] disp;
        bit          noise;
    } vec_t;

    function automatic vec_t mk(logic [3:0] cmd, logic stp, logic [23:0] ent, int dly,
                                logic [7:0] rd, int kind, logic [15:0] maddr,
                                logic [7:0] wd, logic [23:0] disp, bit noise);
        vec_t v;
        v.cmd = cmd; v.stp = stp; v.ent = ent; v.dly = dly; v.rd = rd; v.kind = kind;
        v.maddr = maddr; v.wd = wd; v.disp = disp; v.noise = noise;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmds(input logic [3:0] c);
        {cmd_addr, cmd_dep, cmd_exam, cmd_next} = c;
    endtask

    // Apply one command and follow it to completion.
    task automatic apply(input vec_t v);
        bit acked;
        acked   = 1'b0;
        stopped = v.stp;
        entry   = v.ent;
        set_cmds(v.cmd);
        tick();
        set_cmds(4'b0000);
        entry = 24'($urandom);
        case (v.kind)
            K_IGN: begin
                chk("ign_clear", 32'(clear_entry), 32'(0));
                chk("ign_req", 32'(mem_req), 32'(0));
                chk("ign_load", 32'(disp_load), 32'(0));
                chk("ign_busy", 32'(busy), 32'(0));
                chk("ign_err", 32'(err), 32'(err_exp));
            end
            K_ADR: begin
                chk("adr_clear", 32'(clear_entry), 32'(1));
                chk("adr_load", 32'(disp_load), 32'(1));
                chk("adr_disp", 32'(disp_value), 32'(v.disp));
                chk("adr_req", 32'(mem_req), 32'(0));
                chk("adr_busy", 32'(busy), 32'(0));
                chk("adr_err", 32'(err), 32'(0));
                err_exp = 1'b0;
                tick();
                chk("adr_pulse", 32'({disp_load, clear_entry}), 32'(0));
            end
            default: begin
                chk("bus_start", 32'({clear_entry, mem_req, busy, err, disp_load}), 32'(5'b11100));
                chk("bus_addr", 32'(mem_addr), 32'(v.maddr));
                chk("bus_we", 32'(mem_we), 32'(v.kind == K_WR || (v.kind == K_TO && v.cmd[2] && !v.cmd[3])));
                if (mem_we) chk("bus_wdata", 32'(mem_wdata), 32'(v.wd));
                err_exp = 1'b0;
                for (int j = 1; j <= TIMEOUT; j++) begin
                    mem_ack   = (j == v.dly + 1);
                    mem_rdata = mem_ack ? v.rd : 8'($urandom);
                    if (v.noise) begin
                        stopped = 1'($urandom);
                        set_cmds(4'($urandom));
                        entry = 24'($urandom);
                    end
                    tick();
                    mem_ack = 1'b0;
                    set_cmds(4'b0000);
                    if (j == v.dly + 1) begin
                        chk("ack_req", 32'(mem_req), 32'(0));
                        chk("ack_load", 32'(disp_load), 32'(1));
                        chk("ack_disp", 32'(disp_value), 32'(v.disp));
                        chk("ack_busy", 32'(busy), 32'(1));
                        acked = 1'b1;
                        break;
                    end
                    if (j == TIMEOUT) begin
                        chk("to_req", 32'(mem_req), 32'(0));
                        chk("to_err", 32'(err), 32'(1));
                        chk("to_load", 32'(disp_load), 32'(1));
                        chk("to_disp", 32'(disp_value), 32'(24'hEEEEEE));
                        chk("to_busy", 32'(busy), 32'(0));
                        err_exp = 1'b1;
                    end else begin
                        chk("req_hold", 32'({mem_req, busy, disp_load, mem_addr}),
                            32'({3'b110, v.maddr}));
                        if (mem_we) chk("wdata_hold", 32'(mem_wdata), 32'(v.wd));
                    end
                end
                if (acked) begin
                    if (v.noise) begin
                        stopped = 1'b1;
                        set_cmds(4'($urandom));
                    end
                    tick();
                    set_cmds(4'b0000);
                    chk("done_idle", 32'({busy, disp_load, mem_req, clear_entry}), 32'(0));
                end else begin
                    tick();
                    chk("to_after", 32'({err, disp_load, busy}), 32'(3'b100));
                end
            end
        endcase
    endtask

    vec_t tbl[$];
    logic [15:0] addr_m;
    logic [7:0]  mem_m [logic [15:0]];

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        // Reset state.
        tick();
        tick();
        chk("rst_ctrl", 32'({mem_req, mem_we, disp_load, clear_entry, busy, err}), 32'(0));
        chk("rst_disp", 32'(disp_value), 32'(0));
        chk("rst_addr", 32'({mem_addr, mem_wdata}), 32'(0));
        rst = 1'b0;
        tick();

        tbl.push_back(mk(4'b1000, 1, 24'h001234,  0, 8'h00, K_ADR, 16'h0000, 8'h00, 24'h123400, 0));
        tbl.push_back(mk(4'b0010, 1, 24'h000000,  3, 8'hA5, K_RD,  16'h1234, 8'h00, 24'h1234A5, 0));
        tbl.push_back(mk(4'b1000, 1, 24'h00FFFF,  0, 8'h00, K_ADR, 16'h0000, 8'h00, 24'hFFFF00, 0));
        tbl.push_back(mk(4'b0100, 1, 24'h00003C,  0, 8'h00, K_WR,  16'hFFFF, 8'h3C, 24'hFFFF3C, 0));
        tbl.push_back(mk(4'b0010, 1, 24'h000000,  1, 8'h5A, K_RD,  16'h0000, 8'h00, 24'h00005A, 0));
        tbl.push_back(mk(4'b0001, 1, 24'h000000,  2, 8'h77, K_RD,  16'h0001, 8'h00, 24'h000177, 0));
        tbl.push_back(mk(4'b0110, 1, 24'h000099,  2, 8'h00, K_WR,  16'h0001, 8'h99, 24'h000199, 1));
        tbl.push_back(mk(4'b0010, 0, 24'h000000,  0, 8'h00, K_IGN, 16'h0000, 8'h00, 24'h000000, 0));
        tbl.push_back(mk(4'b0010, 1, 24'h000000, -1, 8'h00, K_TO,  16'h0002, 8'h00, 24'hEEEEEE, 0));
        tbl.push_back(mk(4'b1000, 1, 24'hABFFFF,  0, 8'h00, K_ADR, 16'h0000, 8'h00, 24'hFFFF00, 0));
        tbl.push_back(mk(4'b0001, 1, 24'h000000, 254, 8'h11, K_RD, 16'h0000, 8'h00, 24'h000011, 0));
        tbl.push_back(mk(4'b1111, 1, 24'h004321,  0, 8'h00, K_ADR, 16'h0000, 8'h00, 24'h432100, 0));
        tbl.push_back(mk(4'b0011, 1, 24'h000000,  0, 8'hC3, K_RD,  16'h4321, 8'h00, 24'h4321C3, 0));
        tbl.push_back(mk(4'b0100, 1, 24'h0000D7, -1, 8'h00, K_TO,  16'h4321, 8'hD7, 24'hEEEEEE, 1));
        tbl.push_back(mk(4'b0010, 1, 24'h000000,  0, 8'h01, K_RD,  16'h4321, 8'h00, 24'h432101, 0));
        foreach (tbl[i]) apply(tbl[i]);

        // Stray ack while idle must be ignored.
        mem_ack = 1'b1;
        mem_rdata = 8'h3F;
        tick();
        mem_ack = 1'b0;
        chk("stray_ack", 32'({mem_req, disp_load, busy, clear_entry}), 32'(0));

        // Reset in the middle of a read.
        stopped = 1'b1;
        set_cmds(4'b0010);
        tick();
        set_cmds(4'b0000);
        chk("mid_req", 32'(mem_req), 32'(1));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst", 32'({mem_req, disp_load, busy, err, clear_entry}), 32'(0));
        err_exp = 1'b0;
        apply(mk(4'b0010, 1, 24'h000000, 0, 8'h42, K_RD, 16'h0000, 8'h00, 24'h000042, 0));

        // Randomized run against a transaction-level model.
        addr_m = 16'h0000;
        for (int n = 0; n < 60; n++) begin
            vec_t v;
            int r;
            logic [3:0] c;
            c = 4'($urandom);
            r = int'($urandom_range(0, 19));
            v = mk(c, ($urandom_range(0, 7) != 0), 24'($urandom),
                   (r == 0) ? -1 : (r == 1) ? 254 : int'($urandom_range(0, 5)),
                   8'h00, K_IGN, 16'h0000, 8'h00, 24'h000000, 1'($urandom));
            if (v.stp && c != 4'b0000) begin
                if (c[3]) begin
                    v.kind = K_ADR;
                    addr_m = v.ent[15:0];
                    v.disp = {v.ent[15:0], 8'h00};
                end else begin
                    if (c[2]) begin
                        v.kind = K_WR;
                        v.wd   = v.ent[7:0];
                    end else begin
                        v.kind = K_RD;
                        if (!c[1]) addr_m = addr_m + 16'd1;
                        if (!mem_m.exists(addr_m)) mem_m[addr_m] = 8'($urandom);
                        v.rd = mem_m[addr_m];
                    end
                    v.maddr = addr_m;
                    if (v.dly < 0) begin
                        v.kind = K_TO;
                        v.disp = 24'hEEEEEE;
                    end else if (c[2]) begin
                        v.disp = {addr_m, v.wd};
                        mem_m[addr_m] = v.wd;
                        addr_m = addr_m + 16'd1;
                    end else begin
                        v.disp = {addr_m, v.rd};
                    end
                end
            end
            apply(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
